// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryption round controller with key request interface
// Optional abort input is enabled by defining AES_ROUND_CTRL_ABORT_EN.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Byte x of the table sits at bits [8*(255-x)+7 -: 8], i.e. entry 0x00 is the MSB byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[{~a, 3'b111} -: 8];
endmodule

module aes_subbytes (
    input  logic [127:0] d,
    output logic [127:0] q
);
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (d[8*i +: 8]),
            .y (q[8*i +: 8])
        );
    end
endmodule

module aes_shiftrows (
    input  logic [127:0] d,
    output logic [127:0] q
);
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign q[8*(r + 4*c) +: 8] = d[8*(r + 4*((c + r) % 4)) +: 8];
        end
    end
endmodule

module aes_mixcolumns (
    input  logic [127:0] d,
    output logic [127:0] q
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = d[32*c      +: 8];
        assign a1 = d[32*c + 8  +: 8];
        assign a2 = d[32*c + 16 +: 8];
        assign a3 = d[32*c + 24 +: 8];

        assign q[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign q[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign q[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign q[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    output logic         rk_req,
    input  logic         rk_valid,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    fsm_t         fsm, fsm_nxt;
    logic [127:0] state_reg, state_nxt;
    logic [3:0]   round, round_nxt;
    logic [127:0] sb, sr, mc;
    logic         abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_hit = abort && (fsm != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    aes_subbytes u_subbytes (
        .d (state_reg),
        .q (sb)
    );

    aes_shiftrows u_shiftrows (
        .d (sb),
        .q (sr)
    );

    aes_mixcolumns u_mixcolumns (
        .d (sr),
        .q (mc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            state_reg <= '0;
            round     <= '0;
        end else begin
            fsm       <= fsm_nxt;
            state_reg <= state_nxt;
            round     <= round_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        state_nxt = state_reg;
        round_nxt = round;
        in_ready  = 1'b0;
        rk_req    = 1'b0;
        rk_idx    = 4'd0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_data;
                    round_nxt = 4'd0;
                    fsm_nxt   = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                rk_req = 1'b1;
                rk_idx = round;
                if (rk_valid) begin
                    if (round == 4'd0) begin
                        state_nxt = state_reg ^ rk;
                    end else if (round == LAST_ROUND) begin
                        state_nxt = sr ^ rk;
                        fsm_nxt   = S_DONE;
                    end else begin
                        state_nxt = mc ^ rk;
                    end
                    // The counter parks at the last round instead of wrapping past 10.
                    round_nxt = (round == LAST_ROUND) ? round : round + 4'd1;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_nxt = S_IDLE;
                end
            end
            default: begin
                fsm_nxt = S_IDLE;
            end
        endcase

        // Abort discards the block but leaves state_reg as it was.
        if (abort_hit) begin
            fsm_nxt   = S_IDLE;
            round_nxt = 4'd0;
            state_nxt = state_reg;
        end
    end

    assign out_data = state_reg;
endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption engine controller: accepts one 128-bit plaintext block, sequences ten rounds through a single-round datapath built from the existing `aes_subbytes`, `aes_shiftrows` and `aes_mixcolumns` combinational blocks, and returns the ciphertext. It sits between the block-level valid/ready stream and the external key-schedule unit, which supplies one round key per round over a request/valid interface.

## Interface
- No parameters. AES-128 only, 10 rounds.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: plaintext block offered.
- `in_ready` out 1: controller can accept a block.
- `in_data` in 128: plaintext. Byte i is at [8i+7:8i]. Column c is bytes 4c..4c+3, with byte 4c as row 0.
- `rk_idx` out 4: index of the round key currently requested, 0..10.
- `rk_req` out 1: round key `rk_idx` is requested this cycle.
- `rk_valid` in 1: `rk` holds round key `rk_idx`.
- `rk` in 128: round key, same byte packing as `in_data`.
- `out_valid` out 1: ciphertext available.
- `out_ready` in 1: consumer accepts the ciphertext.
- `out_data` out 128: ciphertext, same byte packing.
- `busy` out 1: high in RUN and DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE. Registers: `state_reg[127:0]`, `round[3:0]`.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`: `state_reg`<=`in_data`, `round`<=0, go to RUN.
- **RUN:**
  - `rk_req`=1 and `rk_idx`=`round`.
  - If `rk_valid`=0: stall; hold `state_reg` and `round`.
  - If `rk_valid`=1, update by round:
    - round 0: `state_reg`<=`state_reg`^`rk`.
    - rounds 1..9: `state_reg`<=MixColumns(ShiftRows(SubBytes(`state_reg`)))^`rk`.
    - round 10: `state_reg`<=ShiftRows(SubBytes(`state_reg`))^`rk`, go to DONE.
  - `round` increments on every consumed key.
  - `in_ready`=0.
- **DONE:**
  - `out_valid`=1 and `out_data`=`state_reg`. Both are held stable until `out_ready`.
  - On `out_ready`: go to IDLE.
- **Outputs outside the states above:**
  - `rk_req`=0 outside RUN.
  - `out_valid`=0 outside DONE.
  - `out_data` always drives `state_reg`.
- **`rk` sampling:** `rk` is sampled only when `rk_req`&&`rk_valid`. The key unit may hold `rk_valid` high between rounds; each round still consumes exactly one key per cycle.
- **In-flight limit:** one block in flight. `in_valid` during RUN or DONE is ignored; the block is not accepted and stays pending.

## Timing
- **Reset values** (`rst` wins over every other event): state IDLE, `state_reg`=0, `round`=0.
  - Resulting outputs: `in_ready`=1, `rk_req`=0, `rk_idx`=0, `out_valid`=0, `out_data`=0, `busy`=0.
- **Reset mid-operation:** reset asserted in RUN or DONE discards the block. No `out_valid` is produced for it.
- **Minimum latency** (with `rk_valid` held high):
  - Accept edge E0.
  - Rounds 0..10 are consumed on edges E1..E11.
  - `out_valid` is high in the cycle after E11, i.e. 11 cycles after acceptance.
  - Each `rk_valid`=0 cycle in RUN adds one cycle.
- **Back-to-back blocks:** `out_ready` high on the first DONE cycle returns to IDLE at the next edge. The next block can be accepted on the edge after that. Minimum issue interval is 13 cycles.
- **DONE/IDLE boundary:** `in_ready` is combinational from state only, so no same-cycle DONE->accept occurs.
- **Round counter:** `round` never exceeds 10. It is reset to 0 on every accept.

## Configuration
- **Macro:** `AES_ROUND_CTRL_ABORT_EN`.
- **Defined:** adds input `abort` (1 bit).
  - `abort` high in RUN or DONE forces IDLE at the next edge and clears `round` to 0. `state_reg` is not cleared.
  - `out_valid` drops; no ciphertext is delivered for the aborted block.
  - `abort` in IDLE has no effect.
  - If `abort` and `in_valid` are both high in IDLE, the block is accepted.
- **Undefined:** no `abort` port; a block always runs to DONE unless `rst` is asserted.

## Test plan
- **FIPS-197 App. B:** `in_data` bytes 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34; key 2b7e151628aed2a6abf7158809cf4f3c expanded by the bench model; `rk_valid` tied high. Required response: `out_data` bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32, with `out_valid` exactly 11 cycles after accept.
- **FIPS-197 App. C.1 with stalls:** pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f; `rk_valid` low for 3 random cycles per round. Required response: ct 69c4e0d86a7b0430d8cdb78070b4c55a; `rk_idx` sequence 0..10 with no skips; latency 11+stalls.
- **Output backpressure:** `out_ready` low for 5 cycles in DONE. Required response: `out_valid` and `out_data` stable throughout; `in_valid` held high meanwhile is not accepted until IDLE.
- **Back-to-back:** two blocks (B and C vectors) issued with `out_ready`=1. Required response: both ciphertexts correct and the second accept exactly 13 cycles after the first.
- **Reset mid-run:** `rst` asserted at round 5 for 1 cycle. Required response: all outputs at reset values on the next cycle, no `out_valid`, and a following block encrypts correctly.
- **Abort (with `AES_ROUND_CTRL_ABORT_EN`):** `abort` at round 3. Required response: IDLE next cycle, `round` back to 0, no `out_valid`; the next block produces a correct ciphertext.
